systolic_result_reader: RTL and testbench

Drain stage for the 3x3 systolic matrix-multiply array. Watches the array's `done` level, snapshots all nine 32-bit accumulator results in one cycle, then streams them out one word per transfer over a valid/ready handshake in row-major order. When the last word has been accepted, it pulses an active-high clear toward the array so the next job can start.

---
 rtl/systolic_result_reader.sv | 181 ++++++++++++++++++
 tb/tb_systolic_result_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_reader.sv
// systolic_result_reader
// Drain stage for the 3x3 systolic array. On a rising edge of array_done it
// snapshots all N_PE accumulator words, streams them row-major over a
// valid/ready handshake, then holds array_clear high for CLR_CYC cycles.
// Optional feature: define RESULT_SAT_EN to saturate each word to the signed
// OUT_W range and report it on the sticky sat_flag; otherwise words are
// truncated to their low OUT_W bits and sat_flag is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a rising edge on array_done
// S_STREAM | presenting buffer[idx] on m_data, advancing on accept
// S_CLEAR  | array_clear high, counting down CLR_CYC cycles

module systolic_result_reader #(
    parameter int N_PE    = 9,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 16,
    parameter int CLR_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PE*IN_W-1:0]   array_out,
    input  logic                   array_done,
    output logic                   array_clear,
    output logic [OUT_W-1:0]       m_data,
    output logic [3:0]             m_idx,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   sat_flag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    localparam int CNT_W = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC + 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_done_q;
    logic [IN_W-1:0]   r_buf [N_PE];
    logic [3:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    logic              w_start;
    logic              w_xfer;
    logic              w_is_last;
    logic              w_cnt_done;
    logic [IN_W-1:0]   w_word;
    logic [OUT_W-1:0]  w_conv;

    // Only an edge seen in IDLE starts a job; done_q resets high so a level
    // already present at reset release is not mistaken for a new job.
    assign w_start    = (r_state == S_IDLE) && array_done && !r_done_q;
    assign w_xfer     = (r_state == S_STREAM) && m_ready;
    assign w_is_last  = (r_idx == 4'(N_PE - 1));
    assign w_cnt_done = (r_cnt == CNT_W'(1));
    assign w_word     = r_buf[r_idx];

`ifdef RESULT_SAT_EN
    logic [IN_W-OUT_W:0] w_top;
    logic                w_in_range;
    logic                r_sat_flag;

    // A word fits the signed OUT_W range when its bits above the OUT_W sign
    // bit are all copies of that sign bit.
    assign w_top      = w_word[IN_W-1:OUT_W-1];
    assign w_in_range = (&w_top) | ~(|w_top);

    // Clamp out-of-range words to the signed extreme matching their sign.
    always_comb begin
        w_conv = w_word[OUT_W-1:0];
        if (!w_in_range) begin
            w_conv = w_word[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Sticky saturation flag, rearmed by each new capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
        end else if (w_start) begin
            r_sat_flag <= 1'b0;
        end else if (w_xfer && !w_in_range) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    assign w_conv   = OUT_W'(w_word);
    assign sat_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_STREAM;
            S_STREAM: if (w_xfer && w_is_last) w_next = S_CLEAR;
            S_CLEAR:  if (w_cnt_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Edge detector, snapshot buffer, word index and clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q <= 1'b1;
            r_idx    <= 4'd0;
            r_cnt    <= '0;
            for (int k = 0; k < N_PE; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_done_q <= array_done;
            if (w_start) begin
                r_idx <= 4'd0;
                for (int k = 0; k < N_PE; k++) begin
                    r_buf[k] <= array_out[k*IN_W +: IN_W];
                end
            end else if (w_xfer) begin
                if (w_is_last) begin
                    r_idx <= 4'd0;
                    r_cnt <= CNT_W'(CLR_CYC);
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end else if (r_state == S_CLEAR) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // busy is registered from the next state so it moves with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
        end
    end

    assign busy = r_busy;

    // Output decode; everything idles at zero outside its own state.
    always_comb begin
        m_valid     = 1'b0;
        m_data      = '0;
        m_idx       = 4'd0;
        m_last      = 1'b0;
        array_clear = 1'b0;
        case (r_state)
            S_STREAM: begin
                m_valid = 1'b1;
                m_data  = w_conv;
                m_idx   = r_idx;
                m_last  = w_is_last;
            end
            S_CLEAR: array_clear = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_result_reader.sv
// Directed bench for systolic_result_reader with a scoreboard queue of
// expected words; honours RESULT_SAT_EN when it is defined for the build.

module tb_systolic_result_reader;

   logic          clk;
   logic          rst_n;
   logic [287:0]  array_out;
   logic          array_done;
   logic          array_clear;
   logic [15:0]   m_data;
   logic [3:0]    m_idx;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          busy;
   logic          sat_flag;

   typedef struct packed {
      logic [3:0]  idx;
      logic [15:0] data;
      logic        last;
      logic        sat;
   } exp_t;

   exp_t        q[$];
   logic [31:0] vals [9];
   logic        exp_sat_flag;
   int          checks   = 0;
   int          failures = 0;

   systolic_result_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .array_out  (array_out),
      .array_done (array_done),
      .array_clear(array_clear),
      .m_data     (m_data),
      .m_idx      (m_idx),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .busy       (busy),
      .sat_flag   (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   function automatic logic exp_sat(input logic [31:0] w);
`ifdef RESULT_SAT_EN
      return ($signed(w) > 32'sd32767) || ($signed(w) < -32'sd32768);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] exp_data(input logic [31:0] w);
`ifdef RESULT_SAT_EN
      if ($signed(w) > 32'sd32767)  return 16'h7FFF;
      if ($signed(w) < -32'sd32768) return 16'h8000;
`endif
      return w[15:0];
   endfunction

   // Drive a frame onto the array bus, push its expectations, raise done.
   task automatic start_job();
      for (int k = 0; k < 9; k++) begin
         array_out[k*32 +: 32] = vals[k];
         q.push_back('{idx: 4'(k), data: exp_data(vals[k]),
                       last: (k == 8), sat: exp_sat(vals[k])});
      end
      exp_sat_flag = 1'b0;
      array_done   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("latency_valid", m_valid, 1'b1);
      chk("latency_busy", busy, 1'b1);
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
   task automatic drain(input int mode, input int nxfer, input bit corrupt);
      int          n = 0;
      int          cyc = 0;
      logic        pstall = 1'b0;
      logic [15:0] pd = '0;
      logic [3:0]  pi = '0;
      logic        pl = 1'b0;
      exp_t        e;
      while (n < nxfer && cyc < 200) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         chk("valid_held", m_valid, 1'b1);
         chk("sat_flag", sat_flag, exp_sat_flag);
         if (pstall) begin
            chk("stall_data", m_data, pd);
            chk("stall_idx", m_idx, pi);
            chk("stall_last", m_last, pl);
         end
         if (m_valid && m_ready) begin
            chk("sb_nonempty", (q.size() > 0), 1'b1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("xfer_idx", m_idx, e.idx);
               chk("xfer_data", m_data, e.data);
               chk("xfer_last", m_last, e.last);
               if (e.sat) exp_sat_flag = 1'b1;
            end
            n++;
         end
         pstall = m_valid && !m_ready;
         pd = m_data;
         pi = m_idx;
         pl = m_last;
         if (corrupt && n == 4) array_out = '1;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      chk("drain_count", n, nxfer);
      m_ready = 1'b0;
   endtask

   // Count the clear pulse; the array drops done once it sees clear.
   task automatic check_clear();
      int c = 0;
      chk("clear_start", array_clear, 1'b1);
      while (array_clear && c < 10) begin
         c++;
         array_done = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      chk("clear_len", c, 2);
      chk("idle_busy", busy, 1'b0);
      chk("idle_valid", m_valid, 1'b0);
      chk("sb_drained", q.size(), 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_last", m_last, 1'b0);
      chk("rst_idx", m_idx, 4'd0);
      chk("rst_data", m_data, 16'h0000);
      chk("rst_clear", array_clear, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sat", sat_flag, 1'b0);
   endtask

   initial begin
      rst_n        = 1'b0;
      array_done   = 1'b1;
      array_out    = '0;
      m_ready      = 1'b0;
      exp_sat_flag = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // done already high at reset release: no job.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("pre_busy", busy, 1'b0);
         chk("pre_valid", m_valid, 1'b0);
      end
      array_done = 1'b0;
      @(negedge clk);

      // Frame 1: k*3+1, ready held high.
      for (int k = 0; k < 9; k++) vals[k] = 32'(k*3 + 1);
      start_job();
      drain(0, 9, 1'b0);
      check_clear();

      // Frame 2: same data, ready 1,0,0 pattern, bus corrupted mid-stream.
      start_job();
      drain(1, 9, 1'b1);
      check_clear();

      // Frame 3: saturation corner values, random ready.
      vals[0] = 32'h00012345; vals[1] = 32'hFFFF0000; vals[2] = 32'hFFFFFFFE;
      vals[3] = 32'h00007FFF; vals[4] = 32'hFFFF8000; vals[5] = 32'h00008000;
      vals[6] = 32'hFFFF7FFF; vals[7] = 32'h80000000; vals[8] = 32'h7FFFFFFF;
      start_job();
      drain(2, 9, 1'b0);
      check_clear();
      chk("sat_sticky", sat_flag, exp_sat_flag);

      // Frame 4: plain values; capture must rearm the flag.
      for (int k = 0; k < 9; k++) vals[k] = 32'(100 + k);
      start_job();
      drain(0, 9, 1'b0);
      check_clear();

      // Frame 5: reset after four transfers.
      for (int k = 0; k < 9; k++) vals[k] = 32'(200 + 7*k);
      start_job();
      drain(0, 4, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      q.delete();
      exp_sat_flag = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_clear", array_clear, 1'b0);
         chk("post_rst_busy", busy, 1'b0);
      end
      array_done = 1'b0;
      @(negedge clk);
      start_job();
      drain(0, 9, 1'b0);
      check_clear();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
